pipe_delay_line: RTL
====================

# pipe_delay_line

Parametrised elastic pipeline register: a chain of `Depth` stages, each holding `NrOfBits` of data plus a valid bit. It replaces hand-placed single-stage datapath registers (PC+4, ALU result and similar) between pipeline stages. On top of plain enable/reset/preset it adds:
- bubble-collapsing backpressure;
- synchronous flush;
- an occupancy count.

## Interface
Parameters:
- `NrOfBits`, 32, data width per stage (≥1)
- `Depth`, 4, number of stages (≥1)
- `ResetValue`, 0, data value loaded on reset and on flush
- `PresetValue`, all ones, data value loaded on preset

Ports:
- `Clock`  in  1  clock, rising edge
- `Reset`  in  1  asynchronous, active-high
- `ClockEnable`  in  1  advance qualifier
- `Tick`  in  1  advance qualifier; `en = ClockEnable & Tick`
- `Flush`  in  1  synchronous clear of all stages
- `Preset`  in  1  synchronous load of `PresetValue` into all stages
- `D`  in  `NrOfBits`  input data
- `DValid`  in  1  input data valid
- `InReady`  out  1  stage 0 can accept this cycle
- `Stall`  in  1  downstream not ready; output stage must hold
- `Q`  out  `NrOfBits`  output stage data
- `QValid`  out  1  output stage valid
- `Count`  out  `$clog2(Depth+1)`  number of valid stages
- `Full`  out  1  `Count == Depth`
- `Empty`  out  1  `Count == 0`

## Operation
- Stage `Depth-1` is the output stage: `Q` and `QValid` show its registers directly.
- Ready chain:
  - `ready[Depth] = en & ~Stall`
  - `ready[i] = en & (~valid[i] | ready[i+1])`
  - `InReady = ready[0] & ~Flush & ~Preset`
- Stage load rules:
  - Stage `i>0` loads from stage `i-1` when `ready[i]`.
  - Stage 0 loads `D`/`DValid` when `ready[0]`.
  - A stage that passes its data on without receiving new data becomes invalid.
- Handshakes:
  - Input fire: `in_fire = DValid & InReady`.
  - Output fire: `out_fire = QValid & ready[Depth]`.
- Bubbles collapse: a stalled output stage does not stop younger valid stages advancing into empty stages ahead of them.
- Data of an invalid stage is don't-care; it is not cleared, except by flush or reset.
- Priority on a clock edge is Reset (async) > `Flush` > `Preset` > normal advance.
  - `Flush` ignores `en`. All valids go to 0, all data to `ResetValue`, `Count` goes to 0, and `D` is not captured.
  - `Preset` ignores `en`. All valids go to 1, all data to `PresetValue`, and `Count` goes to `Depth`.
- Count update: `Count_next = Count + in_fire - out_fire`. Simultaneous in and out leaves `Count` unchanged. It never wraps; it is bounded 0..`Depth` by construction.
- Reset values: all valids 0, all data `ResetValue`, `Q = ResetValue`, `QValid = 0`, `Count = 0`, `Empty = 1`, `Full = 0`.
- `InReady` is 0 during reset and whenever `en = 0`.

## Timing
- Latency is exactly `Depth` rising edges from input fire to `QValid`, with no stall and `en = 1` throughout.
- Throughput is one item per cycle when `en = 1` and `Stall = 0`.
- `InReady` is combinational from `Stall`, `en`, `Flush`, `Preset` and the valids; the chain length is O(`Depth`).
- `Full`, `Empty`, `Q`, `QValid` and `Count` are registered or decoded from registers, with no combinational path from inputs.
- Reset asserted mid-stream discards all contents immediately (asynchronously). The first capture is possible on the first edge after release.
- With `Full = 1` and `Stall = 1`, `InReady` is 0 and contents hold indefinitely.
- With `Full = 1` and `Stall = 0`, `InReady` is 1 (pass-through at full rate).

## Configuration
- `PIPE_DELAY_LINE_TRISTATE_EN` defined:
  - Adds input port `cs` (1 bit).
  - When `cs = 1`, `Q` and `QValid` drive `z`; otherwise they are driven normally.
  - Internal state and `InReady` are unaffected by `cs`.
- Undefined: no `cs` port; `Q` and `QValid` are always driven.

## Structure
- Shared package `pipe_pkg` holds:
  - a `clog2` helper for `Count` width;
  - default `NrOfBits`/`Depth` constants used by the datapath instances.
- One sub-module, `pipe_stage`: a single data+valid register with load, flush and preset inputs and asynchronous Reset, instantiated `Depth` times by a generate loop. The ready chain and counter live in the top.

## Test plan
- Reset then stream, `Depth=4`, `NrOfBits=8`: drive `D=0x11,0x22,0x33` with `DValid=1`, `en=1`, `Stall=0` → `QValid` rises on edge 4, and `Q=0x11,0x22,0x33` on consecutive cycles. `Count` goes 1,2,3,3,2,1,0.
- Bubble collapse: load `0xA1`, idle one cycle, load `0xA2`, then hold `Stall=1` → after 4 more edges `Count=2`, `Full=0`, `InReady=1`, and the two items sit in stages 3 and 2. Release `Stall` → `0xA1` then `0xA2` back-to-back.
- Fill to `Full` with `Stall=1` → `InReady=0`, `Count=4`, and `D` is ignored. Assert `Stall=0` with `DValid=1` → in and out fire on the same edge and `Count` stays 4.
- `Flush` and `Preset` together on one edge while `Full` → `Flush` wins: `Count=0`, `QValid=0`, `Q=ResetValue`. Next cycle `Preset` alone → `Count=4`, `Q=0xFF`.
- `Tick=0` for 3 cycles mid-stream → no movement, `InReady=0`, `Count` constant. Async `Reset` pulse mid-cycle → `QValid=0` and `Count=0` before the next edge.
- With `PIPE_DELAY_LINE_TRISTATE_EN` defined: `cs=1` → `Q` and `QValid` read `z` while `Count` keeps updating. `cs=0` → the held values reappear.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_delay_line slice: default datapath
// dimensions and a constant-function clog2 for sizing the occupancy count.
package pipe_pkg;

  localparam int DefaultNrOfBits = 32;
  localparam int DefaultDepth    = 4;

  // Smallest r such that 2**r >= value (value >= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: NrOfBits of data plus a valid flag.
// Priority on a clock edge: asynchronous Reset > Flush > Preset > Load.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int                  NrOfBits    = DefaultNrOfBits,
  parameter logic [NrOfBits-1:0] ResetValue  = '0,
  parameter logic [NrOfBits-1:0] PresetValue = '1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Flush,
  input  logic                Preset,
  input  logic                Load,
  input  logic [NrOfBits-1:0] DIn,
  input  logic                VIn,
  output logic [NrOfBits-1:0] DOut,
  output logic                VOut
);

  logic [NrOfBits-1:0] data_q, data_d;
  logic                valid_q, valid_d;

  // Next-state selection: flush clears, preset fills, load copies upstream.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (Flush) begin
      data_d  = ResetValue;
      valid_d = 1'b0;
    end else if (Preset) begin
      data_d  = PresetValue;
      valid_d = 1'b1;
    end else if (Load) begin
      data_d  = DIn;
      valid_d = VIn;
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      data_q  <= ResetValue;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign DOut = data_q;
  assign VOut = valid_q;

endmodule

// File: rtl/pipe_delay_line.sv
// Elastic delay line of Depth stages with bubble-collapsing backpressure,
// synchronous flush/preset and a registered occupancy count.
// Optional: define PIPE_DELAY_LINE_TRISTATE_EN to add a 'cs' input that
// floats Q/QValid when high (internal state is unaffected).
module pipe_delay_line
  import pipe_pkg::*;
#(
  parameter int                  NrOfBits    = DefaultNrOfBits,
  parameter int                  Depth       = DefaultDepth,
  parameter logic [NrOfBits-1:0] ResetValue  = '0,
  parameter logic [NrOfBits-1:0] PresetValue = '1
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          ClockEnable,
  input  logic                          Tick,
  input  logic                          Flush,
  input  logic                          Preset,
  input  logic [NrOfBits-1:0]           D,
  input  logic                          DValid,
  output logic                          InReady,
  input  logic                          Stall,
  output logic [NrOfBits-1:0]           Q,
  output logic                          QValid,
  output logic [clog2(Depth+1)-1:0]     Count,
`ifdef PIPE_DELAY_LINE_TRISTATE_EN
  input  logic                          cs,
`endif
  output logic                          Full,
  output logic                          Empty
);

  localparam int CountW = clog2(Depth + 1);

  logic                en;
  logic [Depth:0]      ready;
  logic [Depth-1:0]    valid;
  logic [NrOfBits-1:0] data [Depth];
  logic                in_fire;
  logic                out_fire;
  logic [CountW-1:0]   count_q, count_d;

  assign en = ClockEnable & Tick;

  // The output stage may move only if downstream is ready; every other stage
  // may move if it is empty or the stage ahead of it is moving.
  assign ready[Depth] = en & ~Stall;

  genvar gi;
  generate
    for (gi = 0; gi < Depth; gi++) begin : g_stage
      logic [NrOfBits-1:0] din;
      logic                vin;

      assign ready[gi] = en & (~valid[gi] | ready[gi+1]);

      if (gi == 0) begin : g_head
        assign din = D;
        assign vin = DValid;
      end else begin : g_body
        assign din = data[gi-1];
        assign vin = valid[gi-1];
      end

      pipe_stage #(
        .NrOfBits    (NrOfBits),
        .ResetValue  (ResetValue),
        .PresetValue (PresetValue)
      ) u_stage (
        .Clock  (Clock),
        .Reset  (Reset),
        .Flush  (Flush),
        .Preset (Preset),
        .Load   (ready[gi]),
        .DIn    (din),
        .VIn    (vin),
        .DOut   (data[gi]),
        .VOut   (valid[gi])
      );
    end
  endgenerate

  // Held low during reset so nothing upstream believes a capture happened.
  assign InReady  = ready[0] & ~Flush & ~Preset & ~Reset;
  assign in_fire  = DValid & InReady;
  assign out_fire = valid[Depth-1] & ready[Depth];

  // Occupancy: flush/preset override, otherwise +1 per capture, -1 per drain.
  always_comb begin
    count_d = count_q;
    if (Flush) begin
      count_d = '0;
    end else if (Preset) begin
      count_d = CountW'(Depth);
    end else begin
      count_d = count_q + CountW'(in_fire) - CountW'(out_fire);
    end
  end

  // Occupancy register with asynchronous clear.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Count = count_q;
  assign Full  = (count_q == CountW'(Depth));
  assign Empty = (count_q == '0);

`ifdef PIPE_DELAY_LINE_TRISTATE_EN
  assign Q      = cs ? {NrOfBits{1'bz}} : data[Depth-1];
  assign QValid = cs ? 1'bz : valid[Depth-1];
`else
  assign Q      = data[Depth-1];
  assign QValid = valid[Depth-1];
`endif

endmodule
